// File: rtl/score_digit_blitter.sv
// score_digit_blitter: walks one glyph raster from the glyph ROM into the framebuffer write port
module score_digit_blitter #(
    parameter int GLYPH_W = 11,
    parameter int GLYPH_H = 16,
    parameter int FB_W = 640,
    parameter int FB_H = 480,
    parameter int ADDR_W = 19,
    parameter bit SKIP_BLACK = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        digit,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    output logic              busy,
    output logic              done,
    output logic [3:0]        glyph_sel,
    output logic [9:0]        glyph_row,
    output logic [9:0]        glyph_col,
    input  logic [2:0]        glyph_rgb,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              fb_we,
    input  logic              fb_ready
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    localparam logic [9:0] LAST_COL = 10'(GLYPH_W - 1);
    localparam logic [9:0] LAST_ROW = 10'(GLYPH_H - 1);
    localparam logic [10:0] FB_W11 = 11'(FB_W);
    localparam logic [10:0] FB_H11 = 11'(FB_H);
    state_t state, state_nx;
    logic [9:0] px, py;
    logic [10:0] sx, sy;
    logic [2:0] wdata;
    logic in_bounds, adv, last_col, last;
    assign sx = {1'b0, px} + {1'b0, glyph_col};
    assign sy = {1'b0, py} + {1'b0, glyph_row};
    assign in_bounds = sx < FB_W11 && sy < FB_H11;
    assign wdata = glyph_sel > 4'd9 ? 3'b000 : glyph_rgb;
    assign fb_we = state == WRITE && in_bounds && !(SKIP_BLACK && glyph_sel <= 4'd9 && wdata == 3'b000);
    assign fb_addr = fb_we ? ADDR_W'(32'(sy) * 32'(FB_W) + 32'(sx)) : '0;
    assign fb_data = fb_we ? wdata : 3'b000;
    assign adv = !fb_we || fb_ready;
    assign last_col = glyph_col == LAST_COL;
    assign last = last_col && glyph_row == LAST_ROW;
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_comb begin
        state_nx = state;
        if (state == IDLE && start) state_nx = WRITE;
        if (state == WRITE && adv && last) state_nx = DONE;
        if (state == DONE) state_nx = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            glyph_sel <= '0;
            px <= '0;
            py <= '0;
            glyph_row <= '0;
            glyph_col <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                glyph_sel <= digit;
                px <= pos_x;
                py <= pos_y;
                glyph_row <= '0;
                glyph_col <= '0;
            end else if (state == WRITE && adv) begin
                glyph_col <= last_col ? 10'd0 : glyph_col + 10'd1;
                if (last_col) glyph_row <= last ? 10'd0 : glyph_row + 10'd1;
            end
        end
    end
endmodule

// File: tb/tb_score_digit_blitter.sv
// tb_score_digit_blitter: table, corner-case and random draws against a pixel-index reference model
module tb_score_digit_blitter;
    localparam int GW = 11;
    localparam int GH = 16;
    typedef struct {
        int dg, x, y, first, last, wr0, mid;
    } vec_t;
    logic clk = 0, reset = 1, start = 0, fb_ready = 1;
    logic [3:0] digit = 0;
    logic [9:0] pos_x = 0, pos_y = 0;
    logic busy0, done0, we0, busy1, done1, we1;
    logic [3:0] sel0, sel1;
    logic [9:0] row0, col0, row1, col1;
    logic [2:0] rgb0, rgb1, data0, data1;
    logic [18:0] addr0, addr1;
    int passed = 0, total = 0;
    int ms[2], mp[2], msel[2], mx[2], my[2];
    logic s_done0, s_done1, s_we0, s_we1;
    logic [18:0] s_addr0;
    logic [2:0] s_data0;
    logic [9:0] s_col0;
    vec_t tv[8];

    always #5 clk = ~clk;

    function automatic logic [2:0] rom(input logic [3:0] s, input logic [9:0] r, input logic [9:0] c);
        int a, b;
        a = int'(s) + int'(r) + int'(c);
        b = int'(s) + 2 * int'(r) + int'(c);
        return (a % 3 == 0) ? 3'd0 : 3'(b % 7 + 1);
    endfunction

    assign rgb0 = rom(sel0, row0, col0);
    assign rgb1 = rom(sel1, row1, col1);

    score_digit_blitter #(.SKIP_BLACK(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .digit(digit), .pos_x(pos_x), .pos_y(pos_y),
        .busy(busy0), .done(done0), .glyph_sel(sel0), .glyph_row(row0), .glyph_col(col0),
        .glyph_rgb(rgb0), .fb_addr(addr0), .fb_data(data0), .fb_we(we0), .fb_ready(fb_ready));
    score_digit_blitter #(.SKIP_BLACK(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .digit(digit), .pos_x(pos_x), .pos_y(pos_y),
        .busy(busy1), .done(done1), .glyph_sel(sel1), .glyph_row(row1), .glyph_col(col1),
        .glyph_rgb(rgb1), .fb_addr(addr1), .fb_data(data1), .fb_we(we1), .fb_ready(fb_ready));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void pix(input int k, output logic we, output int addr, output int data,
                                output int r, output int c);
        int sx, sy, w;
        r = mp[k] / GW;
        c = mp[k] % GW;
        sx = mx[k] + c;
        sy = my[k] + r;
        w = msel[k] > 9 ? 0 : int'(rom(4'(msel[k]), 10'(r), 10'(c)));
        we = ms[k] == 1 && sx < 640 && sy < 480 && !(k == 1 && msel[k] <= 9 && w == 0);
        addr = we ? (sy * 640 + sx) % 524288 : 0;
        data = we ? w : 0;
    endfunction

    function automatic int nb(input int dg, input int x, input int y);
        int n = 0;
        for (int r = 0; r < GH; r++)
            for (int c = 0; c < GW; c++)
                if (x + c < 640 && y + r < 480 && (dg > 9 || rom(4'(dg), 10'(r), 10'(c)) != 0)) n++;
        return n;
    endfunction

    task automatic check_dut(input int k);
        logic we;
        int a, d, r, c;
        logic [63:0] act, ex;
        pix(k, we, a, d, r, c);
        ex = {35'd0, ms[k] != 0, ms[k] == 2, 4'(msel[k]), we, 19'(a), 3'(d)};
        act = k == 0 ? {35'd0, busy0, done0, sel0, we0, addr0, data0}
                     : {35'd0, busy1, done1, sel1, we1, addr1, data1};
        chk(k == 0 ? "out0" : "out1", act, ex);
        if (ms[k] == 1)
            chk(k == 0 ? "rowcol0" : "rowcol1", k == 0 ? {44'd0, row0, col0} : {44'd0, row1, col1},
                {44'd0, 10'(r), 10'(c)});
    endtask

    task automatic model_step(input int k);
        logic we;
        int a, d, r, c;
        pix(k, we, a, d, r, c);
        if (reset) begin
            ms[k] = 0; mp[k] = 0; msel[k] = 0;
        end else if (ms[k] == 0) begin
            if (start) begin
                ms[k] = 1; mp[k] = 0; msel[k] = int'(digit); mx[k] = int'(pos_x); my[k] = int'(pos_y);
            end
        end else if (ms[k] == 1) begin
            if (!we || fb_ready) begin
                mp[k]++;
                if (mp[k] == GW * GH) ms[k] = 2;
            end
        end else ms[k] = 0;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        s_done0 = done0; s_done1 = done1; s_we0 = we0; s_we1 = we1;
        s_addr0 = addr0; s_data0 = data0; s_col0 = col0;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic draw(input int dg, input int x, input int y, input int mid, input int pct,
                        output int dcyc, output int wr0, output int wr1, output int first,
                        output int last, output int nd0, output int nd1);
        dcyc = -1; wr0 = 0; wr1 = 0; first = 0; last = 0; nd0 = 0; nd1 = 0;
        digit = 4'(dg); pos_x = 10'(x); pos_y = 10'(y); fb_ready = 1; start = 1;
        cycle();
        start = 0;
        for (int n = 1; n < 2000; n++) begin
            fb_ready = int'($urandom_range(99)) < pct;
            start = n == mid;
            cycle();
            if (s_we0) begin
                if (wr0 == 0) first = int'(s_addr0);
                last = int'(s_addr0);
                wr0++;
            end
            if (s_we1) wr1++;
            if (s_done0) begin
                nd0++;
                if (dcyc < 0) dcyc = n;
            end
            if (s_done1) nd1++;
            if (dcyc >= 0 && ms[0] == 0 && ms[1] == 0 && n > dcyc + 2) break;
        end
        start = 0; fb_ready = 1;
    endtask

    initial begin
        int dcyc, wr0, wr1, first, last, nd0, nd1, nd;
        tv[0] = '{2, 100, 50, 32100, 41710, 176, 0};
        tv[1] = '{7, 635, 470, 301435, 307199, 50, 0};
        tv[2] = '{15, 0, 0, 0, 9610, 176, 0};
        tv[3] = '{3, 639, 479, 307199, 307199, 1, 0};
        tv[4] = '{9, 640, 0, 0, 0, 0, 0};
        tv[5] = '{0, 629, 464, 297589, 307199, 176, 0};
        tv[6] = '{1, 200, 100, 64200, 73810, 176, 50};
        tv[7] = '{12, 1000, 1000, 0, 0, 0, 0};
        for (int k = 0; k < 2; k++) begin
            ms[k] = 0; mp[k] = 0; msel[k] = 0; mx[k] = 0; my[k] = 0;
        end
        cycle();
        cycle();
        reset = 0;
        cycle();
        for (int i = 0; i < 8; i++) begin
            draw(tv[i].dg, tv[i].x, tv[i].y, tv[i].mid, 100, dcyc, wr0, wr1, first, last, nd0, nd1);
            chk("done_cycle", 64'(dcyc), 64'(177));
            chk("writes", 64'(wr0), 64'(tv[i].wr0));
            chk("first_addr", 64'(first), 64'(tv[i].first));
            chk("last_addr", 64'(last), 64'(tv[i].last));
            chk("skip_writes", 64'(wr1), 64'(nb(tv[i].dg, tv[i].x, tv[i].y)));
            chk("done_count0", 64'(nd0), 64'(1));
            chk("done_count1", 64'(nd1), 64'(1));
        end
        digit = 2; pos_x = 100; pos_y = 50; start = 1;
        cycle();
        start = 0;
        for (int n = 1; n <= 5; n++) cycle();
        fb_ready = 0;
        for (int j = 0; j < 3; j++) begin
            cycle();
            chk("bp_addr", 64'(s_addr0), 64'(32105));
            chk("bp_col", 64'(s_col0), 64'(5));
            chk("bp_data", 64'(s_data0), 64'(rom(4'd2, 10'd0, 10'd5)));
        end
        fb_ready = 1;
        dcyc = -1;
        for (int n = 9; n < 600; n++) begin
            cycle();
            if (s_done0) begin
                dcyc = n;
                break;
            end
        end
        chk("bp_done_cycle", 64'(dcyc), 64'(180));
        for (int j = 0; j < 3; j++) cycle();
        digit = 4; pos_x = 10; pos_y = 10; start = 1;
        cycle();
        start = 0;
        for (int n = 1; n <= 80; n++) cycle();
        reset = 1;
        for (int k = 0; k < 2; k++) begin
            ms[k] = 0; mp[k] = 0; msel[k] = 0;
        end
        #1;
        chk("rst_now0", {15'd0, busy0, done0, sel0, row0, col0, we0, addr0, data0}, 64'd0);
        chk("rst_now1", {15'd0, busy1, done1, sel1, row1, col1, we1, addr1, data1}, 64'd0);
        cycle();
        cycle();
        reset = 0;
        nd = 0;
        for (int n = 0; n < 200; n++) begin
            cycle();
            if (s_done0 || s_done1) nd++;
        end
        chk("no_done_after_reset", 64'(nd), 64'd0);
        draw(2, 100, 50, 0, 100, dcyc, wr0, wr1, first, last, nd0, nd1);
        chk("post_rst_done", 64'(dcyc), 64'(177));
        chk("post_rst_first", 64'(first), 64'(32100));
        chk("post_rst_writes", 64'(wr0), 64'(176));
        for (int i = 0; i < 12; i++) begin
            draw(int'($urandom_range(15)), int'($urandom_range(1023)), int'($urandom_range(1023)), 0, 60,
                 dcyc, wr0, wr1, first, last, nd0, nd1);
            chk("rand_done0", 64'(nd0), 64'(1));
            chk("rand_done1", 64'(nd1), 64'(1));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
